slave_out_port_burst: RTL
=========================

Name: slave_out_port_burst

Overview:
- Parametrised successor to the serial slave output port of the system bus.
- Serialises DATA_WIDTH-bit words LSB-first onto a 1-bit tx_data line toward the master.
- Supports multi-word bursts of programmable length, and stalls when upstream slave data is late.
- Sits between slave-side data logic (parallel word plus data_ready) and the bus master's serial receive path.

Parameters:
- DATA_WIDTH, 8, bits per word; legal range 2..32.
- BL_W, 4, width of burst_len; maximum burst is 2^BL_W-1 words.
- CNT_W, 5, width of the internal bit counter; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- master_ready  input  1  master can accept a burst; sampled only in IDLE.
- data_ready  input  1  datain holds a valid word.
- datain  input  DATA_WIDTH  parallel word, LSB transmitted first.
- burst_len  input  BL_W  words in the burst; 0 is treated as 1; sampled at burst start only.
- datain_ack  output  1  one-cycle pulse after each word is captured.
- tx_data  output  1  serial data bit.
- slave_valid  output  1  tx_data carries a valid bit this cycle.
- slave_tx_done  output  1  high during the final bit cycle of a burst.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; tx_data, slave_valid, slave_tx_done, datain_ack and busy all 0; counters and shift register cleared. An in-flight burst is discarded and produces no slave_tx_done.
- All outputs are registered.
- States: IDLE, TX, WAIT.
- IDLE:
  - Outputs held at their reset values.
  - handshake = data_ready & master_ready.
  - On a clock edge with handshake=1: capture datain into the shift register; words_left = max(burst_len,1)-1; tx_data <= datain[0]; slave_valid <= 1; bit_cnt <= 1; datain_ack <= 1; go to TX.
- TX, one bit per cycle:
  - While bit_cnt < DATA_WIDTH: tx_data <= word[bit_cnt]; bit_cnt++.
  - The bit cycle holding word[DATA_WIDTH-1] is the "last-bit cycle".
- At the edge that ends a last-bit cycle:
  - words_left=0: go to IDLE; slave_valid <= 0; tx_data <= 0. slave_tx_done was already driven high during that last-bit cycle (it is set at the edge that issues the last bit).
  - words_left>0 and data_ready=1: capture the next word, pulse datain_ack, tx_data <= bit 0, decrement words_left, stay in TX. There is no idle gap between words.
  - words_left>0 and data_ready=0: go to WAIT; slave_valid <= 0; tx_data <= 0.
- WAIT:
  - Hold words_left.
  - On the first edge with data_ready=1: capture the word exactly as in TX and return to TX.
  - master_ready is ignored.
- master_ready is ignored mid-burst.
- datain_ack is high exactly one cycle per captured word.
- Minimum gap between bursts is one IDLE cycle with slave_valid=0.
- Burst bit latency: the first bit appears in the cycle after the handshake edge.
- Total valid cycles per burst = words × DATA_WIDTH, plus any WAIT cycles during which slave_valid=0.

Optional Feature:
- Macro: SLAVE_OUT_PARITY_EN.
- When defined:
  - One extra valid cycle follows bit DATA_WIDTH-1 of every word, carrying even parity (XOR of all data bits).
  - The parity cycle becomes the last-bit cycle: slave_tx_done aligns with the parity bit of the final word, and data_ready is sampled during the parity cycle.
- When undefined: no parity cycle; timing exactly as described above.

Test Plan:
- Reset release, then master_ready=1, data_ready=1, datain=8'hA5, burst_len=1 -> tx_data 1,0,1,0,0,1,0,1 over 8 cycles; slave_valid high for 8 cycles; slave_tx_done high on the 8th cycle only; datain_ack high for 1 cycle; back to IDLE with busy=0.
- burst_len=3, data_ready held 1, words 8'h01, 8'hFF, 8'h80 -> 24 contiguous valid cycles; datain_ack pulses at cycles 1, 9 and 17; slave_tx_done high only on cycle 24.
- burst_len=2, data_ready dropped during the last-bit cycle of word 1 and raised 3 cycles later -> slave_valid=0 for 3 cycles; word 2 then sent intact; slave_tx_done only at its final bit.
- burst_len=0, datain=8'h3C -> behaves as a 1-word burst; 8 valid cycles.
- Drive reset=0 mid-word (bit 4 of burst 1) -> all outputs 0 immediately; no slave_tx_done; the next burst after release starts from bit 0.
- With SLAVE_OUT_PARITY_EN, datain=8'h07, burst_len=1 -> 9 valid cycles; 9th bit = 1; slave_tx_done on cycle 9.

Source files
------------

// File: rtl/slave_out_port_burst.sv
// Burst-capable serial slave output port: LSB-first words onto tx_data, stalls when upstream data is late.
// Optional even-parity cycle after each word when SLAVE_OUT_PARITY_EN is defined.
module slave_out_port_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int BL_W       = 4,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  master_ready,
  input  logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic [BL_W-1:0]       burst_len,
  output logic                  datain_ack,
  output logic                  tx_data,
  output logic                  slave_valid,
  output logic                  slave_tx_done,
  output logic                  busy
);

`ifdef SLAVE_OUT_PARITY_EN
  localparam int LAST_I = DATA_WIDTH;
`else
  localparam int LAST_I = DATA_WIDTH - 1;
`endif
  // bit_cnt holds the index of the bit currently on the line; LAST marks the last-bit cycle
  localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, TX, WAIT} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [BL_W-1:0]       words_left, words_left_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic                  tx_nxt, valid_nxt, done_nxt, ack_nxt, load;
`ifdef SLAVE_OUT_PARITY_EN
  logic                  par, par_nxt;
`endif

  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    words_left_nxt = words_left;
    bit_cnt_nxt    = bit_cnt;
    tx_nxt         = 1'b0;
    valid_nxt      = 1'b0;
    done_nxt       = 1'b0;
    ack_nxt        = 1'b0;
    load           = 1'b0;
`ifdef SLAVE_OUT_PARITY_EN
    par_nxt        = par;
`endif
    case (state)
      IDLE: begin
        if (data_ready && master_ready) begin
          load           = 1'b1;
          words_left_nxt = (burst_len == '0) ? '0 : burst_len - 1'b1;
        end
      end
      TX: begin
        if (bit_cnt != LAST) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          shreg_nxt   = shreg >> 1;
          valid_nxt   = 1'b1;
`ifdef SLAVE_OUT_PARITY_EN
          tx_nxt      = (bit_cnt == LAST - 1'b1) ? par : shreg[1];
`else
          tx_nxt      = shreg[1];
`endif
          done_nxt    = (bit_cnt_nxt == LAST) && (words_left == '0);
        end else if (words_left == '0) begin
          state_nxt = IDLE;
        end else if (data_ready) begin
          load           = 1'b1;
          words_left_nxt = words_left - 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (data_ready) begin
          load           = 1'b1;
          words_left_nxt = words_left - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // word capture is identical from IDLE, TX and WAIT
    if (load) begin
      state_nxt   = TX;
      shreg_nxt   = datain;
      bit_cnt_nxt = '0;
      tx_nxt      = datain[0];
      valid_nxt   = 1'b1;
      ack_nxt     = 1'b1;
`ifdef SLAVE_OUT_PARITY_EN
      par_nxt     = ^datain;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      shreg         <= '0;
      words_left    <= '0;
      bit_cnt       <= '0;
      tx_data       <= 1'b0;
      slave_valid   <= 1'b0;
      slave_tx_done <= 1'b0;
      datain_ack    <= 1'b0;
      busy          <= 1'b0;
`ifdef SLAVE_OUT_PARITY_EN
      par           <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      shreg         <= shreg_nxt;
      words_left    <= words_left_nxt;
      bit_cnt       <= bit_cnt_nxt;
      tx_data       <= tx_nxt;
      slave_valid   <= valid_nxt;
      slave_tx_done <= done_nxt;
      datain_ack    <= ack_nxt;
      busy          <= (state_nxt != IDLE);
`ifdef SLAVE_OUT_PARITY_EN
      par           <= par_nxt;
`endif
    end
  end

endmodule
